// File: rtl/hdmi_rx_axis.sv
// Pixel-bus receiver that repacks 24-bit RGB into a 32-bit AXI4-Stream video stream.
// Latency: one pixel of lookahead plus one clk via the FWFT FIFO; tready stalls hold the head word and overflow drops to frame end.
module hdmi_rx_axis #(
    parameter int FIFO_DEPTH = 16,
    parameter bit VS_POL     = 1'b1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        pix_ce,
    input  logic        vsync,
    input  logic        de,
    input  logic [23:0] pix_data,
    output logic [31:0] m_axis_video_tdata,
    output logic        m_axis_video_tvalid,
    input  logic        m_axis_video_tready,
    output logic        m_axis_video_tuser,
    output logic        m_axis_video_tlast,
    output logic        overflow,
    input  logic        clr_ovf,
    output logic [11:0] line_len,
    output logic [11:0] frame_lines
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {WAIT_SOF, ACTIVE, DROP} state_t;

    state_t        state_q, state_d;
    logic          vs_prev_q, vs_prev_d;
    logic          hold_vld_q, hold_vld_d;
    logic [23:0]   hold_dat_q, hold_dat_d;
    logic          sof_pend_q, sof_pend_d;
    logic          overflow_q, overflow_d;
    logic [11:0]   pix_cnt_q, pix_cnt_d;
    logic [11:0]   line_cnt_q, line_cnt_d;
    logic [11:0]   line_len_q, line_len_d;
    logic [11:0]   frame_lines_q, frame_lines_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [33:0]   fifo_mem [FIFO_DEPTH];
    logic [33:0]   rd_word;

    logic vs_act, vs_rise;
    logic fifo_vld, fifo_full, pop;
    logic push_req, push, push_last, ovf_evt;

    function automatic logic [11:0] sat_inc(input logic [11:0] v);
        return (v == 12'hFFF) ? v : v + 12'd1;
    endfunction

    function automatic logic [31:0] pack_rgb(input logic [23:0] p);
        return {2'b00, p[23:16], 2'b00, p[15:8], 2'b00, p[7:0], 2'b00};
    endfunction

    always_comb begin
        vs_act    = (vsync == VS_POL);
        vs_rise   = pix_ce && vs_act && !vs_prev_q;
        fifo_vld  = (cnt_q != '0);
        fifo_full = (cnt_q == CW'(FIFO_DEPTH));
        pop       = fifo_vld && m_axis_video_tready;

        // The held pixel goes out on every strobe; it closes the line when de drops or a frame starts.
        push_req  = pix_ce && (state_q == ACTIVE) && hold_vld_q;
        push_last = vs_rise || !de;
        ovf_evt   = push_req && fifo_full && !pop;
        push      = push_req && !ovf_evt;

        state_d       = state_q;
        vs_prev_d     = vs_prev_q;
        hold_vld_d    = hold_vld_q;
        hold_dat_d    = hold_dat_q;
        sof_pend_d    = sof_pend_q;
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_len_d    = line_len_q;
        frame_lines_d = frame_lines_q;

        if (pix_ce) begin
            vs_prev_d = vs_act;
            if (ovf_evt) begin
                state_d   = DROP;
                pix_cnt_d = '0;
            end
            if (push) begin
                sof_pend_d = 1'b0;
                if (push_last) begin
                    line_len_d = sat_inc(pix_cnt_q);
                    pix_cnt_d  = '0;
                    line_cnt_d = sat_inc(line_cnt_q);
                end else begin
                    pix_cnt_d  = sat_inc(pix_cnt_q);
                end
            end
            // A frame only counts as complete if it was received without a drop.
            if (vs_rise) begin
                if (state_q == ACTIVE) begin
                    frame_lines_d = line_cnt_d;
                end
                state_d    = ACTIVE;
                sof_pend_d = 1'b1;
                line_cnt_d = '0;
                pix_cnt_d  = '0;
            end
            hold_vld_d = (state_d == ACTIVE) && de;
            if (de) begin
                hold_dat_d = pix_data;
            end
        end

        overflow_d = ovf_evt || (overflow_q && !clr_ovf);

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        cnt_d    = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= WAIT_SOF;
            vs_prev_q     <= 1'b0;
            hold_vld_q    <= 1'b0;
            hold_dat_q    <= '0;
            sof_pend_q    <= 1'b0;
            overflow_q    <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_len_q    <= '0;
            frame_lines_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            vs_prev_q     <= vs_prev_d;
            hold_vld_q    <= hold_vld_d;
            hold_dat_q    <= hold_dat_d;
            sof_pend_q    <= sof_pend_d;
            overflow_q    <= overflow_d;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_len_q    <= line_len_d;
            frame_lines_q <= frame_lines_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {sof_pend_q, push_last, pack_rgb(hold_dat_q)};
        end
    end

    // Storage is not reset, so the outputs are masked to zero whenever the FIFO is empty.
    assign rd_word             = fifo_mem[rd_ptr_q];
    assign m_axis_video_tvalid = fifo_vld;
    assign m_axis_video_tdata  = fifo_vld ? rd_word[31:0] : '0;
    assign m_axis_video_tlast  = fifo_vld && rd_word[32];
    assign m_axis_video_tuser  = fifo_vld && rd_word[33];
    assign overflow            = overflow_q;
    assign line_len            = line_len_q;
    assign frame_lines         = frame_lines_q;

endmodule

// File: tb/tb_hdmi_rx_axis.sv
// Self-checking bench for hdmi_rx_axis: table vectors, framed random traffic and overflow/reset corner cases.
module tb_hdmi_rx_axis;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        pix_ce = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [23:0] pix_data = '0;
    logic        tready = 1'b0;
    logic        clr_ovf = 1'b0;
    logic [31:0] tdata;
    logic        tvalid, tuser, tlast, overflow;
    logic [11:0] line_len, frame_lines;

    always #5 clk = ~clk;

    hdmi_rx_axis #(.FIFO_DEPTH(16), .VS_POL(1'b1)) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .pix_ce              (pix_ce),
        .vsync               (vsync),
        .de                  (de),
        .pix_data            (pix_data),
        .m_axis_video_tdata  (tdata),
        .m_axis_video_tvalid (tvalid),
        .m_axis_video_tready (tready),
        .m_axis_video_tuser  (tuser),
        .m_axis_video_tlast  (tlast),
        .overflow            (overflow),
        .clr_ovf             (clr_ovf),
        .line_len            (line_len),
        .frame_lines         (frame_lines)
    );

    typedef struct packed {
        logic        user;
        logic        last;
        logic [31:0] dat;
    } beat_t;

    typedef struct {
        logic [23:0] pix;
        logic [31:0] exp_dat;
    } vec_t;

    beat_t exp_q[$];
    beat_t stall_beat;
    bit    stall = 1'b0;
    int    vectors = 0;
    int    miscompares = 0;
    int    rdy_mode = 0;   // 0: tready low, 1: tready high, 2: random

    function automatic logic [31:0] fmt(input logic [23:0] p);
        return {2'b00, p[23:16], 2'b00, p[15:8], 2'b00, p[7:0], 2'b00};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic pix(input logic vs, input logic de_i, input logic [23:0] p);
        @(posedge clk);
        #1;
        vsync = vs;
        de = de_i;
        pix_data = p;
        pix_ce = 1'b1;
        @(posedge clk);
        #1;
        pix_ce = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic vs_pulse();
        pix(1'b1, 1'b0, 24'h0);
        pix(1'b0, 1'b0, 24'h0);
    endtask

    // Reference: every pixel of the frame leaves in order, tuser on the first, tlast on each line end.
    task automatic send_frame(input int nl, input int np, input bit expect_out);
        logic [23:0] px;
        vs_pulse();
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < np; p++) begin
                px = 24'($urandom);
                if (expect_out) exp_q.push_back({(l == 0 && p == 0), (p == np - 1), fmt(px)});
                pix(1'b0, 1'b1, px);
            end
            pix(1'b0, 1'b0, 24'h0);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tvalid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL %s drain: %0d beats still expected, tvalid %b", name, exp_q.size(), tvalid);
        end
    endtask

    task automatic mon_step();
        beat_t cur;
        beat_t e;
        cur = {tuser, tlast, tdata};
        if (!rstn) begin
            stall = 1'b0;
            return;
        end
        if (stall) begin
            vectors++;
            if (!tvalid || cur !== stall_beat) begin
                miscompares++;
                $display("FAIL stall_stable: got v=%b %h expected v=1 %h", tvalid, cur, stall_beat);
            end
        end
        stall = tvalid && !tready;
        stall_beat = cur;
        if (tvalid && tready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL beat: got unexpected %h expected no beat", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    miscompares++;
                    $display("FAIL beat: got %h expected %h", cur, e);
                end
            end
        end
    endtask

    initial begin
        vec_t tbl[5];
        tbl[0] = '{24'hFF8001, 32'h3FC80004};
        tbl[1] = '{24'h000000, 32'h00000000};
        tbl[2] = '{24'hFFFFFF, 32'h3FCFF3FC};
        tbl[3] = '{24'h123456, 32'h04834158};
        tbl[4] = '{24'h800000, 32'h20000000};

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk);
                #1;
                case (rdy_mode)
                    0:       tready = 1'b0;
                    1:       tready = 1'b1;
                    default: tready = 1'($urandom_range(0, 1));
                endcase
            end
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", tvalid, 0);
        check("rst_tdata", tdata, 0);
        check("rst_tuser", tuser, 0);
        check("rst_tlast", tlast, 0);
        check("rst_overflow", overflow, 0);
        check("rst_line_len", line_len, 0);
        check("rst_frame_lines", frame_lines, 0);
        @(posedge clk);
        #1 rstn = 1'b1;

        // Traffic before any frame start is ignored
        rdy_mode = 1;
        for (int i = 0; i < 4; i++) pix(1'b0, 1'b1, 24'($urandom));
        pix(1'b0, 1'b0, 24'h0);
        repeat (5) @(negedge clk);
        check("pre_sof_tvalid", tvalid, 0);

        // 4 x 8 frame with tready high
        send_frame(4, 8, 1'b1);
        vs_pulse();
        wait_drain("frame4x8");
        check("f4x8_line_len", line_len, 8);
        check("f4x8_frame_lines", frame_lines, 4);

        // Table vectors as single-pixel lines
        vs_pulse();
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back({(i == 0), 1'b1, tbl[i].exp_dat});
            pix(1'b0, 1'b1, tbl[i].pix);
            pix(1'b0, 1'b0, 24'h0);
        end
        vs_pulse();
        wait_drain("table");
        check("tbl_line_len", line_len, 1);
        check("tbl_frame_lines", frame_lines, 5);

        // Frame start while a pixel is held flushes it as a line end
        vs_pulse();
        begin
            logic [23:0] a, b, c;
            a = 24'hA1B2C3; b = 24'h0F1E2D; c = 24'h55AA11;
            exp_q.push_back({1'b1, 1'b0, fmt(a)});
            exp_q.push_back({1'b0, 1'b1, fmt(b)});
            exp_q.push_back({1'b1, 1'b1, fmt(c)});
            pix(1'b0, 1'b1, a);
            pix(1'b0, 1'b1, b);
            pix(1'b1, 1'b0, 24'h0);
            check("flush_line_len", line_len, 2);
            check("flush_frame_lines", frame_lines, 1);
            pix(1'b0, 1'b0, 24'h0);
            pix(1'b0, 1'b1, c);
            pix(1'b0, 1'b0, 24'h0);
        end
        vs_pulse();
        wait_drain("flush");
        check("single_line_len", line_len, 1);

        // Random backpressure
        rdy_mode = 2;
        send_frame(4, 8, 1'b1);
        send_frame(4, 8, 1'b1);
        vs_pulse();
        wait_drain("random_rdy");
        check("rand_overflow", overflow, 0);
        check("rand_frame_lines", frame_lines, 4);

        // Overflow: 20-pixel line into a 16-deep FIFO with tready low
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        vs_pulse();
        begin
            logic [23:0] px;
            for (int p = 0; p < 20; p++) begin
                px = 24'($urandom);
                if (p < 16) exp_q.push_back({(p == 0), 1'b0, fmt(px)});
                pix(1'b0, 1'b1, px);
            end
            pix(1'b0, 1'b0, 24'h0);
        end
        @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_tvalid", tvalid, 1);
        rdy_mode = 1;
        wait_drain("ovf_drain");
        for (int p = 0; p < 6; p++) pix(1'b0, 1'b1, 24'($urandom));
        pix(1'b0, 1'b0, 24'h0);
        repeat (5) @(negedge clk);
        check("drop_tvalid", tvalid, 0);
        check("ovf_sticky", overflow, 1);
        @(posedge clk);
        #1 clr_ovf = 1'b1;
        @(posedge clk);
        #1 clr_ovf = 1'b0;
        check("ovf_cleared", overflow, 0);
        send_frame(1, 3, 1'b1);
        vs_pulse();
        wait_drain("post_ovf");
        check("post_ovf_line_len", line_len, 3);

        // Reset mid-frame discards buffered beats
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        send_frame(1, 5, 1'b0);
        @(negedge clk);
        check("pre_rst_tvalid", tvalid, 1);
        rstn = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", tvalid, 0);
        check("midrst_line_len", line_len, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        rdy_mode = 1;
        for (int i = 0; i < 3; i++) pix(1'b0, 1'b1, 24'($urandom));
        pix(1'b0, 1'b0, 24'h0);
        repeat (5) @(negedge clk);
        check("post_rst_tvalid", tvalid, 0);
        send_frame(2, 4, 1'b1);
        vs_pulse();
        wait_drain("post_rst");
        check("post_rst_line_len", line_len, 4);
        check("post_rst_frame_lines", frame_lines, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
